// File: rtl/ic7420_checker_if.sv
// ic7420_checker_if: pin bundle between the checker and an ic7420 device under test.
//   a..d : gate-1 inputs of the ic7420 (driven by the checker)
//   e..h : gate-2 inputs of the ic7420 (driven by the checker)
//   x    : gate-1 output, ~&{a,b,c,d} (driven by the device)
//   y    : gate-2 output, ~&{e,f,g,h} (driven by the device)
// Modports:
//   master : checker side, drives a..h and observes x,y
//   slave  : device side, observes a..h and drives x,y
interface ic7420_checker_if;
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
    logic h;
    logic x;
    logic y;

    modport master (
        output a, b, c, d, e, f, g, h,
        input  x, y
    );

    modport slave (
        input  a, b, c, d, e, f, g, h,
        output x, y
    );
endinterface

// File: rtl/ic7420_checker.sv
// ic7420_checker: exhaustive self-checking exerciser for a dual 4-input NAND (ic7420).
// Sweeps all 256 input vectors {a,b,c,d,e,f,g,h} = 0x00..0xFF, waits SETTLE_CYCLES after
// each drive, compares x,y against the NAND truth table and accumulates results.
// Ports:
//   clk        : single clock, all state on the rising edge
//   rst        : synchronous active-high reset
//   start      : begin a sweep; only honoured in the idle state
//   pins       : ic7420 pin bundle (master side: drives a..h, observes x,y)
//   busy       : high from the drive of vector 0 through the check of vector 255
//   done       : one-cycle pulse when the sweep completes
//   pass       : no failing vectors in the last sweep; held until the next accepted start
//   err_count  : number of failing vectors, saturating at all-ones
//   fail_vec   : first failing vector {a,b,c,d,e,f,g,h}
//   fail_valid : fail_vec holds a captured value
module ic7420_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    ic7420_checker_if.master pins,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       fail_vec,
    output logic             fail_valid
);

    localparam bit          HasSettle = SETTLE_CYCLES > 0;
    // Counter only ever holds SETTLE_CYCLES-1 down to 0.
    localparam int unsigned CntW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CntW-1:0] SettleLoad = HasSettle ? CntW'(SETTLE_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StCheck,
        StDone
    } state_e;

    state_e          state_q;
    logic [7:0]      vec_q;
    logic [CntW-1:0] settle_q;

    logic exp_x;
    logic exp_y;
    logic mismatch;
    logic err_full;

    // The vector register drives the pins directly, so a..h are registered and
    // track vec exactly (including holding 0xFF after the last vector).
    assign pins.a = vec_q[7];
    assign pins.b = vec_q[6];
    assign pins.c = vec_q[5];
    assign pins.d = vec_q[4];
    assign pins.e = vec_q[3];
    assign pins.f = vec_q[2];
    assign pins.g = vec_q[1];
    assign pins.h = vec_q[0];

    // x,y only feed state updates below; they never reach an output combinationally.
    assign exp_x    = ~&vec_q[7:4];
    assign exp_y    = ~&vec_q[3:0];
    assign mismatch = (pins.x != exp_x) | (pins.y != exp_y);
    assign err_full = &err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            vec_q      <= '0;
            settle_q   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        vec_q      <= '0;
                        err_count  <= '0;
                        fail_vec   <= '0;
                        fail_valid <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        state_q    <= StDrive;
                    end
                end

                StDrive: begin
                    if (HasSettle) begin
                        settle_q <= SettleLoad;
                        state_q  <= StSettle;
                    end else begin
                        state_q  <= StCheck;
                    end
                end

                StSettle: begin
                    if (settle_q == '0) begin
                        state_q  <= StCheck;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end

                StCheck: begin
                    // One count per failing vector, regardless of how many outputs differ.
                    if (mismatch) begin
                        if (!err_full) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (!fail_valid) begin
                            fail_vec   <= vec_q;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (vec_q == 8'hFF) begin
                        busy    <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        vec_q   <= vec_q + 8'd1;
                        state_q <= StDrive;
                    end
                end

                StDone: begin
                    // err_count already includes the last vector's result here.
                    done    <= 1'b1;
                    pass    <= (err_count == '0);
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ic7420_checker.sv
module tb_ic7420_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start0;
    logic start1;
    int   mode0;
    int   mode1;
    logic [1:0] flip_tab [256];

    int tests = 0;
    int fails = 0;

    // Device modes: 0 golden, 1 x stuck 1, 2 y stuck 0, 3 x/y swapped, 4 random flip table.
    function automatic logic [1:0] dut_resp(input logic [7:0] v, input int m,
                                            input logic [1:0] flip);
        logic gx;
        logic gy;
        gx = (v[7:4] == 4'hF) ? 1'b0 : 1'b1;
        gy = (v[3:0] == 4'hF) ? 1'b0 : 1'b1;
        case (m)
            1:       return {1'b1, gy};
            2:       return {gx, 1'b0};
            3:       return {gy, gx};
            4:       return {gx, gy} ^ flip;
            default: return {gx, gy};
        endcase
    endfunction

    ic7420_checker_if pins0 ();
    ic7420_checker_if pins1 ();

    logic [7:0] vec0;
    logic [7:0] vec1;
    assign vec0 = {pins0.a, pins0.b, pins0.c, pins0.d, pins0.e, pins0.f, pins0.g, pins0.h};
    assign vec1 = {pins1.a, pins1.b, pins1.c, pins1.d, pins1.e, pins1.f, pins1.g, pins1.h};
    assign {pins0.x, pins0.y} = dut_resp(vec0, mode0, flip_tab[vec0]);
    assign {pins1.x, pins1.y} = dut_resp(vec1, mode1, flip_tab[vec1]);

    logic       busy0, done0, pass0, fvalid0;
    logic [8:0] err0;
    logic [7:0] fvec0;
    logic       busy1, done1, pass1, fvalid1;
    logic [3:0] err1;
    logic [7:0] fvec1;

    ic7420_checker #(.SETTLE_CYCLES(2), .ERR_W(9)) u_chk0 (
        .clk        (clk),
        .rst        (rst),
        .start      (start0),
        .pins       (pins0),
        .busy       (busy0),
        .done       (done0),
        .pass       (pass0),
        .err_count  (err0),
        .fail_vec   (fvec0),
        .fail_valid (fvalid0)
    );

    ic7420_checker #(.SETTLE_CYCLES(0), .ERR_W(4)) u_chk1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .pins       (pins1),
        .busy       (busy1),
        .done       (done1),
        .pass       (pass1),
        .err_count  (err1),
        .fail_vec   (fvec1),
        .fail_valid (fvalid1)
    );

    function automatic logic [31:0] get_done(input int inst);
        return (inst == 0) ? 32'(done0) : 32'(done1);
    endfunction
    function automatic logic [31:0] get_busy(input int inst);
        return (inst == 0) ? 32'(busy0) : 32'(busy1);
    endfunction
    function automatic logic [31:0] get_pass(input int inst);
        return (inst == 0) ? 32'(pass0) : 32'(pass1);
    endfunction
    function automatic logic [31:0] get_err(input int inst);
        return (inst == 0) ? 32'(err0) : 32'(err1);
    endfunction
    function automatic logic [31:0] get_fvec(input int inst);
        return (inst == 0) ? 32'(fvec0) : 32'(fvec1);
    endfunction
    function automatic logic [31:0] get_fvalid(input int inst);
        return (inst == 0) ? 32'(fvalid0) : 32'(fvalid1);
    endfunction
    function automatic logic [31:0] get_vec(input int inst);
        return (inst == 0) ? 32'(vec0) : 32'(vec1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the first nvec vectors, judge each against the NAND truth table.
    task automatic ref_model(input int m, input int errw, input int nvec,
                             output int err, output int first);
        int sat;
        sat   = (1 << errw) - 1;
        err   = 0;
        first = -1;
        for (int v = 0; v < nvec; v++) begin
            logic [7:0] vb;
            logic [1:0] got;
            int ex;
            int ey;
            vb  = 8'(v);
            got = dut_resp(vb, m, flip_tab[v]);
            ex  = ((v >> 4) == 15) ? 0 : 1;
            ey  = ((v % 16) == 15) ? 0 : 1;
            if (int'(got[1]) != ex || int'(got[0]) != ey) begin
                if (err < sat) err++;
                if (first < 0) first = v;
            end
        end
    endtask

    task automatic set_start(input int inst, input logic val);
        if (inst == 0) start0 = val;
        else start1 = val;
    endtask

    // Pulse start, then count cycles until done (bounded); optional stray start pulse.
    task automatic run_sweep(input int inst, input int restart_at, output int cycles);
        set_start(inst, 1'b1);
        @(posedge clk);
        #1;
        set_start(inst, 1'b0);
        check("busy_at_start", get_busy(inst), 32'd1);
        check("vec_at_start", get_vec(inst), 32'd0);
        cycles = 0;
        while (get_done(inst) !== 32'd1 && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
            set_start(inst, (cycles == restart_at) ? 1'b1 : 1'b0);
        end
        set_start(inst, 1'b0);
    endtask

    task automatic check_results(input string tag, input int inst, input int m,
                                 input int errw, input int lat_exp, input int cycles);
        int err;
        int first;
        ref_model(m, errw, 256, err, first);
        check({tag, "_latency"}, 32'(cycles), 32'(lat_exp));
        check({tag, "_err_count"}, get_err(inst), 32'(err));
        check({tag, "_fail_valid"}, get_fvalid(inst), (first >= 0) ? 32'd1 : 32'd0);
        check({tag, "_fail_vec"}, get_fvec(inst), (first >= 0) ? 32'(first) : 32'd0);
        check({tag, "_pass"}, get_pass(inst), (err == 0) ? 32'd1 : 32'd0);
        check({tag, "_busy_end"}, get_busy(inst), 32'd0);
        check({tag, "_vec_end"}, get_vec(inst), 32'hFF);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, get_done(inst), 32'd0);
        check({tag, "_err_hold"}, get_err(inst), 32'(err));
        check({tag, "_pass_hold"}, get_pass(inst), (err == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic check_reset(input string tag, input int inst);
        check({tag, "_busy"}, get_busy(inst), 32'd0);
        check({tag, "_done"}, get_done(inst), 32'd0);
        check({tag, "_pass"}, get_pass(inst), 32'd0);
        check({tag, "_err"}, get_err(inst), 32'd0);
        check({tag, "_fvec"}, get_fvec(inst), 32'd0);
        check({tag, "_fvalid"}, get_fvalid(inst), 32'd0);
        check({tag, "_vec"}, get_vec(inst), 32'd0);
    endtask

    initial begin
        int cyc;
        int err;
        int first;
        int waited;

        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mode0  = 0;
        mode1  = 0;
        for (int i = 0; i < 256; i++) flip_tab[i] = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst0", 0);
        check_reset("rst1", 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Golden device.
        mode0 = 0;
        run_sweep(0, -1, cyc);
        check_results("golden", 0, 0, 9, 1025, cyc);
        check("golden_pass_const", get_pass(0), 32'd1);

        // x stuck at 1.
        mode0 = 1;
        run_sweep(0, -1, cyc);
        check_results("x_stuck1", 0, 1, 9, 1025, cyc);
        check("x_stuck1_err_const", get_err(0), 32'd16);
        check("x_stuck1_fvec_const", get_fvec(0), 32'hF0);

        // y stuck at 0.
        mode0 = 2;
        run_sweep(0, -1, cyc);
        check_results("y_stuck0", 0, 2, 9, 1025, cyc);
        check("y_stuck0_err_const", get_err(0), 32'd240);
        check("y_stuck0_fvec_const", get_fvec(0), 32'h00);

        // Outputs swapped.
        mode0 = 3;
        run_sweep(0, -1, cyc);
        check_results("swapped", 0, 3, 9, 1025, cyc);
        check("swapped_err_const", get_err(0), 32'd30);
        check("swapped_fvec_const", get_fvec(0), 32'h0F);

        // Stray start mid-sweep must be ignored.
        mode0 = 0;
        run_sweep(0, 500, cyc);
        check_results("restart", 0, 0, 9, 1025, cyc);

        // Reset mid-sweep at vector 0x40, with errors already accumulated.
        mode0  = 2;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        waited = 0;
        while (vec0 !== 8'h40 && waited < 2000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("reach_vec40", (waited < 2000) ? 32'd1 : 32'd0, 32'd1);
        ref_model(2, 9, 64, err, first);
        check("pre_rst_err", get_err(0), 32'(err));
        check("pre_rst_fvalid", get_fvalid(0), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset("midrst", 0);
        mode0 = 0;
        run_sweep(0, -1, cyc);
        check_results("post_rst", 0, 0, 9, 1025, cyc);

        // Random fault tables on both configurations.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 256; i++) begin
                flip_tab[i] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
            mode0 = 4;
            run_sweep(0, -1, cyc);
            check_results("random0", 0, 4, 9, 1025, cyc);
            mode1 = 4;
            run_sweep(1, -1, cyc);
            check_results("random1", 1, 4, 4, 513, cyc);
        end

        // No settle cycles, narrow saturating counter, x stuck at 1.
        mode1 = 1;
        run_sweep(1, -1, cyc);
        check_results("sat", 1, 1, 4, 513, cyc);
        check("sat_err_const", get_err(1), 32'd15);
        check("sat_fvec_const", get_fvec(1), 32'hF0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
